uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
UART transmitter. It is the transmit-side counterpart to the oversampling receiver in the same UART system. The block accepts a parallel byte with a valid strobe and serialises it as one frame on TX_OUT: start bit, 8 data bits LSB first, optional parity bit, stop bit. Each bit is held for exactly `prescale` clock cycles on the same oversampled clock that the receiver uses, so both ends share one clock and one prescale setting.

Parameters:
- PRESCALE_WIDTH, 5: width of the prescale input and of the internal edge counter.
- DATA_WIDTH, 8: payload bits per frame.

Ports:
- CLK, input, 1: oversampled system clock.
- RST, input, 1: asynchronous, active-high reset.
- P_DATA, input, DATA_WIDTH: byte to transmit. Sampled on accept.
- DATA_VALID, input, 1: request to send P_DATA.
- parity_enable, input, 1: 1 inserts a parity bit. Sampled on accept.
- parity_type, input, 1: 0 selects even parity, 1 selects odd. Sampled on accept.
- prescale, input, PRESCALE_WIDTH: clock cycles per bit. Sampled on accept.
- TX_OUT, output, 1: serial line. Idle level is 1.
- busy, output, 1: high while a frame is in flight.

Behaviour:
- Reset (asynchronous, active-high):
  - TX_OUT=1, busy=0, FSM=IDLE, counters=0.
  - Takes effect immediately, including mid-frame. The frame is aborted; no partial stop bit is emitted.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If DATA_VALID=1, latch P_DATA, parity_enable, parity_type and prescale, then go to START.
- Latency: DATA_VALID is sampled high at edge N. From edge N+1, TX_OUT=0 and busy=1.
- Bit timing:
  - The edge counter runs 0 to eff_prescale-1 within each bit.
  - bit_done is asserted when the counter equals eff_prescale-1. The counter then wraps to 0 and the FSM advances.
  - eff_prescale = latched prescale, except values 0 and 1, which are forced to 2.
- START: TX_OUT=0 for eff_prescale cycles, then go to DATA.
- DATA:
  - TX_OUT = data_reg[bit_idx], with bit_idx running 0 to DATA_WIDTH-1.
  - bit_idx increments on each bit_done.
  - After the last data bit: go to PARITY if parity was enabled, otherwise go to STOP.
- PARITY:
  - TX_OUT = (XOR of data_reg) XOR parity_type.
  - Held for eff_prescale cycles, then go to STOP.
- STOP:
  - TX_OUT=1 for eff_prescale cycles.
  - On bit_done, go to IDLE and drop busy on the same edge.
- Frame length: eff_prescale×10 cycles without parity, eff_prescale×11 with parity, counted from the first start-bit cycle to the last stop-bit cycle.
- Minimum gap: one idle cycle (TX_OUT=1) between back-to-back frames, because acceptance happens only in IDLE.
- DATA_VALID while busy=1 is ignored. There is no queue and no error flag; the upstream block must wait for busy=0.
- Changes to P_DATA, prescale or parity inputs mid-frame have no effect on the frame in flight.
- DATA_VALID held high continuously produces back-to-back frames. Each frame uses the P_DATA value present in its accept cycle.

Decomposition:
- Shared package uart_pkg, containing:
  - FSM state encoding (3-bit, 5 states).
  - Parity-type constants PAR_EVEN=0 and PAR_ODD=1.
  - MIN_PRESCALE=2.
  - Frame bit-count constants.
- One sub-module, uart_tx_bit_timer:
  - Inputs: eff_prescale, run.
  - Outputs: bit_done and bit index.
  - Function: the edge/bit counter with its wrap logic. The parent FSM consumes bit_done.

Test Plan:
1. prescale=8, parity_enable=1, parity_type=0, P_DATA=0xA5, DATA_VALID pulse for 1 cycle → TX_OUT sequence, 8 cycles each: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. busy high for exactly 88 cycles, starting the cycle after accept.
2. prescale=16, parity_enable=0, P_DATA=0xFF → start 0, eight 1s, stop 1, 160 cycles total. No parity slot; busy falls after cycle 160.
3. prescale=4, parity_enable=1, P_DATA=0x01:
   - parity_type=0 → parity bit 1.
   - parity_type=1 → parity bit 0.
4. During frame 1 (0x3C), pulse DATA_VALID with P_DATA=0x55 → 0x55 is never transmitted. TX_OUT returns to 1 and stays idle.
5. DATA_VALID held high with P_DATA=0x12, then 0x34 → two consecutive frames separated by exactly 1 idle-high cycle.
6. Assert RST at cycle 30 of a prescale=8 frame → TX_OUT=1 and busy=0 immediately. After RST deasserts, a new DATA_VALID for 0x7E transmits a clean full frame.
7. prescale=0 → each bit lasts 2 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity
// selection constants, minimum bit length and frame bit counts.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Shortest bit length that still leaves the receiver a mid-bit sample.
  localparam int MIN_PRESCALE = 2;

  localparam int START_BITS        = 1;
  localparam int DATA_BITS         = 8;
  localparam int PARITY_BITS       = 1;
  localparam int STOP_BITS         = 1;
  localparam int FRAME_BITS_NO_PAR = START_BITS + DATA_BITS + STOP_BITS;
  localparam int FRAME_BITS_PAR    = FRAME_BITS_NO_PAR + PARITY_BITS;

  // Wide enough to count every bit position of the longest frame.
  localparam int BIT_IDX_W = 4;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timer for the UART transmitter. Counts clock edges inside each bit,
// flags the last edge of a bit and tracks the bit position within the frame
// (0 = start bit, 1..DATA_WIDTH = data bits, then parity/stop).
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [PRESCALE_WIDTH-1:0] eff_prescale,
  input  logic                      run,
  output logic                      bit_done,
  output logic [BIT_IDX_W-1:0]      bit_idx
);

  logic [PRESCALE_WIDTH-1:0] edge_cnt;

  // Last edge of the current bit; the parent FSM advances on this.
  assign bit_done = run && (edge_cnt == (eff_prescale - PRESCALE_WIDTH'(1)));

  // Edge counter wraps at each bit boundary; both counters park at 0 when idle.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (RST) begin
      edge_cnt <= '0;
      bit_idx  <= '0;
    end else if (!run) begin
      edge_cnt <= '0;
      bit_idx  <= '0;
    end else if (bit_done) begin
      edge_cnt <= '0;
      bit_idx  <= bit_idx + BIT_IDX_W'(1);
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one byte per accepted request as
// start, DATA_WIDTH data bits LSB first, optional parity, stop. Every bit is
// held for eff_prescale clocks. TX_OUT and busy are registered from the
// next-state decode so they change on the same edge as the FSM.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 5,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int                   DIDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_IDX_W-1:0] LAST_DATA_POS = BIT_IDX_W'(DATA_WIDTH);

  tx_state_e                 state, state_next;
  logic [DATA_WIDTH-1:0]     data_reg;
  logic                      par_en_reg;
  logic                      par_type_reg;
  logic [PRESCALE_WIDTH-1:0] prescale_reg;
  logic [PRESCALE_WIDTH-1:0] eff_prescale;
  logic                      run;
  logic                      accept;
  logic                      bit_done;
  logic [BIT_IDX_W-1:0]      bit_idx;
  logic [BIT_IDX_W-1:0]      next_pos;
  logic [DIDX_W-1:0]         data_idx;
  logic                      tx_next;

  // Prescale 0 and 1 are stretched to the minimum usable bit length.
  assign eff_prescale = (prescale_reg < PRESCALE_WIDTH'(MIN_PRESCALE))
                      ? PRESCALE_WIDTH'(MIN_PRESCALE) : prescale_reg;
  assign run    = (state != ST_IDLE);
  assign accept = (state == ST_IDLE) && DATA_VALID;

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .CLK         (CLK),
    .RST         (RST),
    .eff_prescale(eff_prescale),
    .run         (run),
    .bit_done    (bit_done),
    .bit_idx     (bit_idx)
  );

  // Next-state decode: each state lasts one bit, DATA lasts DATA_WIDTH bits.
  always_comb begin
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:   if (DATA_VALID) state_next = ST_START;
      ST_START:  if (bit_done)   state_next = ST_DATA;
      ST_DATA:   if (bit_done && (bit_idx == LAST_DATA_POS))
                   state_next = par_en_reg ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done)   state_next = ST_STOP;
      ST_STOP:   if (bit_done)   state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Line level for the coming cycle, derived from the state and bit position
  // that will be current after this edge.
  always_comb begin
    next_pos = bit_done ? (bit_idx + BIT_IDX_W'(1)) : bit_idx;
    data_idx = DIDX_W'(next_pos - BIT_IDX_W'(1));
    tx_next  = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = data_reg[data_idx];
      ST_PARITY: tx_next = (^data_reg) ^ (par_type_reg == PAR_ODD);
      default:   tx_next = 1'b1;
    endcase
  end

  // FSM and output registers; frame settings are captured only on accept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      TX_OUT       <= 1'b1;
      busy         <= 1'b0;
      data_reg     <= '0;
      par_en_reg   <= 1'b0;
      par_type_reg <= PAR_EVEN;
      prescale_reg <= '0;
    end else begin
      state  <= state_next;
      TX_OUT <= tx_next;
      busy   <= (state_next != ST_IDLE);
      if (accept) begin
        data_reg     <= P_DATA;
        par_en_reg   <= parity_enable;
        par_type_reg <= parity_type;
        prescale_reg <= prescale;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame. A frame-level model expands every
// accepted request into a queue of per-cycle line levels; a compare process
// checks TX_OUT/busy against it every cycle. Directed frames also check the
// sampled bit centres and frame lengths against hand-written literals.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int PW = 5;
  localparam int DW = 8;

  logic          CLK           = 1'b0;
  logic          RST           = 1'b1;
  logic [DW-1:0] P_DATA        = '0;
  logic          DATA_VALID    = 1'b0;
  logic          parity_enable = 1'b0;
  logic          parity_type   = 1'b0;
  logic [PW-1:0] prescale      = '0;
  logic          TX_OUT;
  logic          busy;

  int n_checks = 0;
  int n_fails  = 0;

  uart_tx_frame #(
    .PRESCALE_WIDTH(PW),
    .DATA_WIDTH    (DW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .P_DATA       (P_DATA),
    .DATA_VALID   (DATA_VALID),
    .parity_enable(parity_enable),
    .parity_type  (parity_type),
    .prescale     (prescale),
    .TX_OUT       (TX_OUT),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit   exp_q[$];
  logic exp_tx   = 1'b1;
  logic exp_busy = 1'b0;

  function automatic void build_frame(input logic [7:0] d, input logic pe, input logic pt,
                                      input logic [PW-1:0] ps);
    int eff;
    int ones;
    bit bits[$];
    eff  = (int'(ps) < MIN_PRESCALE) ? MIN_PRESCALE : int'(ps);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) bits.push_back(((ones % 2) == 1) ^ (pt == PAR_ODD));
    bits.push_back(1'b1);
    foreach (bits[b]) for (int k = 0; k < eff; k++) exp_q.push_back(bits[b]);
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_q.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else begin
      if (!exp_busy && DATA_VALID) build_frame(P_DATA, parity_enable, parity_type, prescale);
      if (exp_q.size() > 0) begin
        exp_tx   = exp_q.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
    end
  end

  // Cycle compare against the model.
  always @(negedge CLK) begin
    if (!RST) begin
      check("cyc_tx_out", 32'(TX_OUT), 32'(exp_tx));
      check("cyc_busy",   32'(busy),   32'(exp_busy));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 600) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_idle_timeout"}, 32'(busy), 32'(1'b0));
  endtask

  // Sends one frame, records the line while busy, then checks the length and
  // the centre of every bit. exp_bits[i] is frame bit i (bit 0 = start).
  task automatic send_and_measure(input string name, input logic [7:0] d, input logic pe,
                                  input logic pt, input logic [PW-1:0] ps, input int eff,
                                  input int nbits, input logic [10:0] exp_bits,
                                  input int inject_at);
    logic tx_s [0:511];
    int   len;
    @(negedge CLK);
    P_DATA = d; parity_enable = pe; parity_type = pt; prescale = ps; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID    = 1'b0;
    P_DATA        = 8'($urandom);
    parity_enable = 1'($urandom);
    parity_type   = 1'($urandom);
    prescale      = PW'($urandom);
    len = 0;
    while (busy === 1'b1 && len < 512) begin
      DATA_VALID = (len == inject_at);
      if (len == inject_at) P_DATA = 8'h55;
      tx_s[len] = TX_OUT;
      len++;
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    check({name, "_len"}, 32'(len), 32'(eff * nbits));
    for (int b = 0; b < nbits; b++)
      check($sformatf("%s_bit%0d", name, b), 32'(tx_s[b * eff + eff / 2]), 32'(exp_bits[b]));
    check({name, "_after_tx"}, 32'(TX_OUT), 32'(1'b1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int gap;

    repeat (3) @(negedge CLK);
    check("reset_tx_out", 32'(TX_OUT), 32'(1'b1));
    check("reset_busy",   32'(busy),   32'(1'b0));
    #2 RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle_tx_out", 32'(TX_OUT), 32'(1'b1));

    // 0xA5, prescale 8, even parity: 0 10100101 (LSB first) parity 0, stop 1.
    send_and_measure("a5_par_even", 8'hA5, 1'b1, PAR_EVEN, 5'd8, 8, 11, 11'b10101001010, -1);
    // 0xFF, prescale 16, no parity.
    send_and_measure("ff_nopar", 8'hFF, 1'b0, PAR_EVEN, 5'd16, 16, 10, 11'b01111111110, -1);
    // 0x01, prescale 4: even parity bit 1, odd parity bit 0.
    send_and_measure("01_even", 8'h01, 1'b1, PAR_EVEN, 5'd4, 4, 11, 11'b11000000010, -1);
    send_and_measure("01_odd",  8'h01, 1'b1, PAR_ODD,  5'd4, 4, 11, 11'b10000000010, -1);
    // 0x3C with a 0x55 request injected mid-frame that must be dropped.
    send_and_measure("3c_inject", 8'h3C, 1'b0, PAR_EVEN, 5'd4, 4, 10, 11'b01001111000, 10);
    repeat (20) @(negedge CLK);
    check("inject_dropped_tx",   32'(TX_OUT), 32'(1'b1));
    check("inject_dropped_busy", 32'(busy),   32'(1'b0));
    // Prescale 0 and 1 both give 2-cycle bits.
    send_and_measure("96_ps0", 8'h96, 1'b0, PAR_EVEN, 5'd0, 2, 10, 11'b01100101100, -1);
    send_and_measure("96_ps1", 8'h96, 1'b0, PAR_EVEN, 5'd1, 2, 10, 11'b01100101100, -1);

    // Back-to-back frames with DATA_VALID held high.
    @(negedge CLK);
    P_DATA = 8'h12; prescale = 5'd2; parity_enable = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    P_DATA = 8'h34;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      @(negedge CLK);
      cnt++;
    end
    check("b2b_first_len", 32'(cnt), 32'd20);
    gap = 0;
    while (busy !== 1'b1 && gap < 10) begin
      @(negedge CLK);
      gap++;
    end
    check("b2b_gap", 32'(gap), 32'd1);
    check("b2b_second_start", 32'(TX_OUT), 32'(1'b0));
    DATA_VALID = 1'b0;
    wait_idle("b2b");
    @(negedge CLK);

    // Reset in the middle of a prescale 8 frame (busy cycle 30 lies in d2 = 0).
    @(negedge CLK);
    P_DATA = 8'h00; prescale = 5'd8; parity_enable = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (29) @(negedge CLK);
    check("pre_rst_tx", 32'(TX_OUT), 32'(1'b0));
    #2 RST = 1'b1;
    #1;
    check("mid_rst_tx",   32'(TX_OUT), 32'(1'b1));
    check("mid_rst_busy", 32'(busy),   32'(1'b0));
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    send_and_measure("7e_after_rst", 8'h7E, 1'b0, PAR_EVEN, 5'd8, 8, 10, 11'b01011111100, -1);

    // Randomised traffic: requests at random, mid-frame input noise.
    for (int c = 0; c < 2500; c++) begin
      @(negedge CLK);
      DATA_VALID    = ($urandom_range(0, 3) == 0);
      P_DATA        = 8'($urandom);
      parity_enable = 1'($urandom);
      parity_type   = 1'($urandom);
      prescale      = PW'($urandom_range(0, 6));
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_idle("random");
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
